// File: rtl/mem_ctrl_if.sv
// Bus bundle between the IF/MEM pipeline stages, the memory controller and the byte-wide RAM.
// The controller takes the slave side; requesters and the RAM sit on the master side.
interface mem_ctrl_if #(
  parameter int RAM_ADDR_W = 17
);
  logic                  if_req_i;
  logic [31:0]           if_addr_i;
  logic [31:0]           if_data_o;
  logic                  if_done_o;
  logic                  mem_ce_i;
  logic                  mem_we_i;
  logic [31:0]           mem_addr_i;
  logic [3:0]            mem_sel_i;
  logic [31:0]           mem_data_i;
  logic [31:0]           mem_data_o;
  logic                  mem_done_o;
  logic                  stallreq_o;
  logic [RAM_ADDR_W-1:0] ram_addr_o;
  logic                  ram_we_o;
  logic [7:0]            ram_dout_o;
  logic [7:0]            ram_din_i;

  modport slave (
    input  if_req_i, if_addr_i, mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i, ram_din_i,
    output if_data_o, if_done_o, mem_data_o, mem_done_o, stallreq_o, ram_addr_o, ram_we_o, ram_dout_o
  );

  modport master (
    output if_req_i, if_addr_i, mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i, ram_din_i,
    input  if_data_o, if_done_o, mem_data_o, mem_done_o, stallreq_o, ram_addr_o, ram_we_o, ram_dout_o
  );
endinterface

// File: rtl/mem_ctrl.sv
// Shared byte-wide RAM controller for instruction fetch and the MEM stage.
// MEM has fixed priority; each selected lane becomes one byte access, lane 0 = data[31:24].
module mem_ctrl #(
  parameter int RAM_ADDR_W = 17
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t                state_r, state_n;
  logic [1:0]            lane_r, lane_n, prev_lane_r, prev_lane_n;
  logic [3:0]            rem_r, rem_n;
  logic                  prev_vld_r, prev_vld_n;
  logic                  we_r, we_n, gmem_r, gmem_n;
  logic [RAM_ADDR_W-3:0] addr_r, addr_n;
  logic [31:0]           wdata_r, wdata_n, result_r, result_n;
  logic [31:0]           if_data_r, if_data_n, mem_data_r, mem_data_n;
  logic                  if_done_r, if_done_n, mem_done_r, mem_done_n;
  logic [RAM_ADDR_W-1:0] ram_addr_r, ram_addr_n;
  logic                  ram_we_r, ram_we_n;
  logic [7:0]            ram_dout_r, ram_dout_n;
  logic [3:0]            gsel_s;
  logic                  unused_s;

  function automatic logic [1:0] first_lane(input logic [3:0] m);
    if (m[3])      return 2'd0;
    else if (m[2]) return 2'd1;
    else if (m[1]) return 2'd2;
    else           return 2'd3;
  endfunction

  function automatic logic [3:0] lane_bit(input logic [1:0] k);
    return 4'b1000 >> k;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] d, input logic [1:0] k);
    case (k)
      2'd0:    return d[31:24];
      2'd1:    return d[23:16];
      2'd2:    return d[15:8];
      default: return d[7:0];
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] d, input logic [1:0] k, input logic [7:0] b);
    logic [31:0] r;
    r = d;
    case (k)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

  // Next-state, lane sequencing, byte capture and registered output values.
  always_comb begin
    state_n     = state_r;
    lane_n      = lane_r;
    rem_n       = rem_r;
    prev_lane_n = prev_lane_r;
    prev_vld_n  = 1'b0;
    we_n        = we_r;
    gmem_n      = gmem_r;
    addr_n      = addr_r;
    wdata_n     = wdata_r;
    result_n    = result_r;
    if_data_n   = if_data_r;
    mem_data_n  = mem_data_r;
    if_done_n   = 1'b0;
    mem_done_n  = 1'b0;
    ram_addr_n  = '0;
    ram_we_n    = 1'b0;
    ram_dout_n  = 8'h00;
    gsel_s      = 4'b0000;
    case (state_r)
      IDLE: begin
        if (bus.mem_ce_i) begin
          gmem_n     = 1'b1;
          gsel_s     = bus.mem_sel_i;
          we_n       = bus.mem_we_i;
          addr_n     = bus.mem_addr_i[RAM_ADDR_W-1:2];
          wdata_n    = bus.mem_data_i;
          mem_data_n = 32'h0000_0000;
        end else if (bus.if_req_i) begin
          gmem_n    = 1'b0;
          gsel_s    = 4'b1111;
          we_n      = 1'b0;
          addr_n    = bus.if_addr_i[RAM_ADDR_W-1:2];
          wdata_n   = 32'h0000_0000;
          if_data_n = 32'h0000_0000;
        end else begin
          gsel_s = 4'b0000;
        end
        if (bus.mem_ce_i || bus.if_req_i) begin
          result_n = 32'h0000_0000;
          if (gsel_s == 4'b0000) begin
            state_n = DONE;
          end else begin
            state_n    = ISSUE;
            lane_n     = first_lane(gsel_s);
            rem_n      = gsel_s & ~lane_bit(lane_n);
            ram_addr_n = {addr_n, lane_n};
            ram_we_n   = we_n;
            ram_dout_n = we_n ? get_byte(wdata_n, lane_n) : 8'h00;
          end
        end else begin
          state_n = IDLE;
        end
      end
      ISSUE: begin
        // RAM data arriving now belongs to the lane put on the bus last cycle.
        if (prev_vld_r) result_n = put_byte(result_r, prev_lane_r, bus.ram_din_i);
        else            result_n = result_r;
        prev_vld_n  = ~we_r;
        prev_lane_n = lane_r;
        if (rem_r != 4'b0000) begin
          state_n    = ISSUE;
          lane_n     = first_lane(rem_r);
          rem_n      = rem_r & ~lane_bit(lane_n);
          ram_addr_n = {addr_r, lane_n};
          ram_we_n   = we_r;
          ram_dout_n = we_r ? get_byte(wdata_r, lane_n) : 8'h00;
        end else begin
          state_n = we_r ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (prev_vld_r) result_n = put_byte(result_r, prev_lane_r, bus.ram_din_i);
        else            result_n = result_r;
        state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (state_n == DONE) begin
      if (gmem_n) begin
        mem_done_n = 1'b1;
        mem_data_n = result_n;
      end else begin
        if_done_n = 1'b1;
        if_data_n = result_n;
      end
    end else begin
      mem_done_n = 1'b0;
      if_done_n  = 1'b0;
    end
  end

  // State, latched request and registered bus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      lane_r      <= 2'd0;
      rem_r       <= 4'b0000;
      prev_lane_r <= 2'd0;
      prev_vld_r  <= 1'b0;
      we_r        <= 1'b0;
      gmem_r      <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= 32'h0000_0000;
      result_r    <= 32'h0000_0000;
      if_data_r   <= 32'h0000_0000;
      mem_data_r  <= 32'h0000_0000;
      if_done_r   <= 1'b0;
      mem_done_r  <= 1'b0;
      ram_addr_r  <= '0;
      ram_we_r    <= 1'b0;
      ram_dout_r  <= 8'h00;
    end else begin
      state_r     <= state_n;
      lane_r      <= lane_n;
      rem_r       <= rem_n;
      prev_lane_r <= prev_lane_n;
      prev_vld_r  <= prev_vld_n;
      we_r        <= we_n;
      gmem_r      <= gmem_n;
      addr_r      <= addr_n;
      wdata_r     <= wdata_n;
      result_r    <= result_n;
      if_data_r   <= if_data_n;
      mem_data_r  <= mem_data_n;
      if_done_r   <= if_done_n;
      mem_done_r  <= mem_done_n;
      ram_addr_r  <= ram_addr_n;
      ram_we_r    <= ram_we_n;
      ram_dout_r  <= ram_dout_n;
    end
  end

  assign bus.if_data_o  = if_data_r;
  assign bus.if_done_o  = if_done_r;
  assign bus.mem_data_o = mem_data_r;
  assign bus.mem_done_o = mem_done_r;
  assign bus.ram_addr_o = ram_addr_r;
  assign bus.ram_we_o   = ram_we_r;
  assign bus.ram_dout_o = ram_dout_r;
  assign bus.stallreq_o = (bus.mem_ce_i & ~mem_done_r) | (bus.if_req_i & ~if_done_r);

  assign unused_s = ^{bus.if_addr_i[31:RAM_ADDR_W], bus.if_addr_i[1:0],
                      bus.mem_addr_i[31:RAM_ADDR_W], bus.mem_addr_i[1:0]};
endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: byte-RAM model, shadow-memory reference and per-feature scenarios.
// Expected traces, latencies and data come from the lane list implied by sel.
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_ctrl_if #(.RAM_ADDR_W(17)) bus ();
  mem_ctrl #(.RAM_ADDR_W(17)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  bit [7:0]    ram    [0:131071];
  bit [7:0]    shadow [0:131071];
  logic        pre_we = 1'b0;
  logic [16:0] pre_addr = 17'd0;
  logic [7:0]  pre_data = 8'h00;

  int n_tests = 0;
  int n_fail  = 0;

  logic [16:0] tr_addr [0:15];
  logic        tr_we   [0:15];
  logic [7:0]  tr_dout [0:15];
  logic        tr_stall[0:15];
  logic        after_done;

  // Byte-wide synchronous RAM: address sampled at the edge, data valid the next cycle.
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (bus.ram_we_o) ram[bus.ram_addr_o] <= bus.ram_dout_o;
    bus.ram_din_i <= ram[bus.ram_addr_o];
  end

  // t-th lane visited (1-based) for a select mask, or -1 when there are fewer lanes.
  function automatic int exp_lane(input logic [3:0] sel, input int t);
    int c = 0;
    for (int k = 0; k < 4; k++) begin
      if (sel[3-k]) begin
        c++;
        if (c == t) return k;
      end
    end
    return -1;
  endfunction

  function automatic int exp_lat(input logic we, input logic [3:0] sel);
    int n = $countones(sel);
    if (n == 0) return 1;
    return we ? n + 1 : n + 2;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [3:0] sel);
    logic [31:0] r = 32'h0;
    for (int k = 0; k < 4; k++)
      if (sel[3-k]) r[31-8*k -: 8] = shadow[{a[16:2], 2'(k)}];
    return r;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [3:0] sel, input logic [31:0] d);
    for (int k = 0; k < 4; k++)
      if (sel[3-k]) shadow[{a[16:2], 2'(k)}] = d[31-8*k -: 8];
  endtask

  task automatic preload(input logic [16:0] a, input logic [7:0] b);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = b;
    shadow[a] = b;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic run_access(input bit use_mem, input bit we, input logic [31:0] a, input logic [3:0] sel,
                            input logic [31:0] d, output int lat, output logic [31:0] rdata);
    @(negedge clk);
    if (use_mem) begin
      bus.mem_ce_i = 1'b1; bus.mem_we_i = we; bus.mem_addr_i = a; bus.mem_sel_i = sel; bus.mem_data_i = d;
    end else begin
      bus.if_req_i = 1'b1; bus.if_addr_i = a;
    end
    #1 tr_stall[0] = bus.stallreq_o;
    lat = -1;
    rdata = 32'h0;
    for (int t = 1; t < 16; t++) begin
      @(negedge clk);
      tr_addr[t] = bus.ram_addr_o; tr_we[t] = bus.ram_we_o; tr_dout[t] = bus.ram_dout_o;
      tr_stall[t] = bus.stallreq_o;
      if (use_mem ? bus.mem_done_o : bus.if_done_o) begin
        lat = t;
        rdata = use_mem ? bus.mem_data_o : bus.if_data_o;
        break;
      end
    end
    bus.mem_ce_i = 1'b0; bus.if_req_i = 1'b0;
    @(negedge clk);
    after_done = use_mem ? bus.mem_done_o : bus.if_done_o;
  endtask

  task automatic test_reset();
    logic [92:0] obs;
    rst = 1'b0;
    @(negedge clk);
    obs = {bus.if_data_o, bus.if_done_o, bus.mem_data_o, bus.mem_done_o, bus.stallreq_o,
           bus.ram_addr_o, bus.ram_we_o, bus.ram_dout_o};
    n_tests++;
    if (obs !== 93'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", obs); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    obs = {bus.if_data_o, bus.if_done_o, bus.mem_data_o, bus.mem_done_o, bus.stallreq_o,
           bus.ram_addr_o, bus.ram_we_o, bus.ram_dout_o};
    n_tests++;
    if (obs !== 93'd0) begin n_fail++; $display("FAIL idle_outputs: got %h expected 0", obs); end
  endtask

  task automatic test_word_fetch();
    int lat; logic [31:0] rd; bit bad = 1'b0;
    preload(17'h100, 8'h11); preload(17'h101, 8'h22); preload(17'h102, 8'h33); preload(17'h103, 8'h44);
    run_access(1'b0, 1'b0, 32'h0000_0100, 4'b1111, 32'h0, lat, rd);
    n_tests++;
    if (lat !== 6) begin n_fail++; $display("FAIL fetch_latency: got %0d expected 6", lat); end
    n_tests++;
    if (rd !== 32'h1122_3344) begin n_fail++; $display("FAIL fetch_data: got %h expected 11223344", rd); end
    for (int t = 1; t <= 4; t++) if (tr_addr[t] !== 17'h100 + 17'(t - 1) || tr_we[t] !== 1'b0) bad = 1'b1;
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL fetch_addr_trace: got %h %h %h %h expected 100..103",
                                     tr_addr[1], tr_addr[2], tr_addr[3], tr_addr[4]); end
    n_tests++;
    if (after_done !== 1'b0) begin n_fail++; $display("FAIL fetch_done_pulse: got %b expected 0", after_done); end
  endtask

  task automatic test_byte_load();
    int lat; logic [31:0] rd;
    preload(17'h203, 8'hAB);
    run_access(1'b1, 1'b0, 32'h0000_0203, 4'b0001, 32'h0, lat, rd);
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("FAIL byte_latency: got %0d expected 3", lat); end
    n_tests++;
    if (rd !== 32'h0000_00AB) begin n_fail++; $display("FAIL byte_data: got %h expected 000000ab", rd); end
    n_tests++;
    if (tr_addr[1] !== 17'h203 || tr_addr[2] !== 17'h0) begin
      n_fail++; $display("FAIL byte_addr_trace: got %h %h expected 203 0", tr_addr[1], tr_addr[2]);
    end
    n_tests++;
    if ({tr_stall[0], tr_stall[1], tr_stall[2], tr_stall[3]} !== 4'b1110) begin
      n_fail++; $display("FAIL byte_stall: got %b%b%b%b expected 1110", tr_stall[0], tr_stall[1], tr_stall[2], tr_stall[3]);
    end
  endtask

  task automatic test_word_store();
    int lat; logic [31:0] rd; bit bad = 1'b0;
    run_access(1'b1, 1'b1, 32'h0000_0040, 4'b1111, 32'hDEAD_BEEF, lat, rd);
    model_store(32'h40, 4'b1111, 32'hDEAD_BEEF);
    n_tests++;
    if (lat !== 5) begin n_fail++; $display("FAIL store_latency: got %0d expected 5", lat); end
    for (int t = 1; t <= 4; t++)
      if (tr_addr[t] !== 17'h40 + 17'(t - 1) || tr_we[t] !== 1'b1) bad = 1'b1;
    if (tr_dout[1] !== 8'hDE || tr_dout[2] !== 8'hAD || tr_dout[3] !== 8'hBE || tr_dout[4] !== 8'hEF) bad = 1'b1;
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL store_trace: got %h/%h %h/%h %h/%h %h/%h expected 40/de 41/ad 42/be 43/ef",
                                     tr_addr[1], tr_dout[1], tr_addr[2], tr_dout[2], tr_addr[3], tr_dout[3], tr_addr[4], tr_dout[4]); end
    n_tests++;
    if ({ram[17'h40], ram[17'h41], ram[17'h42], ram[17'h43]} !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL store_ram: got %h%h%h%h expected deadbeef", ram[17'h40], ram[17'h41], ram[17'h42], ram[17'h43]);
    end
  endtask

  task automatic test_simultaneous();
    int mem_t = -1; int if_t = -1; logic [31:0] mem_got = 32'h0; logic [31:0] if_got = 32'h0;
    logic [16:0] a1 = 17'h0; logic [16:0] a2 = 17'h0;
    preload(17'h12, 8'h5A); preload(17'h13, 8'hC3);
    preload(17'h0, 8'h01); preload(17'h1, 8'h02); preload(17'h2, 8'h03); preload(17'h3, 8'h04);
    @(negedge clk);
    bus.mem_ce_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_addr_i = 32'h12; bus.mem_sel_i = 4'b0011;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h0;
    for (int t = 1; t < 24; t++) begin
      @(negedge clk);
      if (t == 1) a1 = bus.ram_addr_o;
      if (t == 2) a2 = bus.ram_addr_o;
      if (bus.mem_done_o) begin
        if (mem_t < 0) mem_t = t;
        mem_got = bus.mem_data_o;
        bus.mem_ce_i = 1'b0;
      end
      if (bus.if_done_o) begin if_t = t; if_got = bus.if_data_o; bus.if_req_i = 1'b0; break; end
    end
    bus.mem_ce_i = 1'b0; bus.if_req_i = 1'b0;
    n_tests++;
    if (mem_t !== 4 || a1 !== 17'h12 || a2 !== 17'h13) begin
      n_fail++; $display("FAIL arb_mem_first: got done T%0d addr %h %h expected T4 12 13", mem_t, a1, a2);
    end
    n_tests++;
    if (if_t !== 11) begin n_fail++; $display("FAIL arb_if_done: got T%0d expected T11", if_t); end
    n_tests++;
    if (mem_got !== 32'h0000_5AC3 || if_got !== 32'h0102_0304) begin
      n_fail++; $display("FAIL arb_data: got %h %h expected 00005ac3 01020304", mem_got, if_got);
    end
  endtask

  task automatic test_reset_mid_store();
    logic [92:0] obs; bit spurious = 1'b0;
    for (int i = 0; i < 4; i++) preload(17'h40 + 17'(i), 8'h11);
    @(negedge clk);
    bus.mem_ce_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_addr_i = 32'h40; bus.mem_sel_i = 4'b1111;
    bus.mem_data_i = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    rst = 1'b0; bus.mem_ce_i = 1'b0;
    #1 obs = {bus.if_data_o, bus.if_done_o, bus.mem_data_o, bus.mem_done_o, bus.stallreq_o,
              bus.ram_addr_o, bus.ram_we_o, bus.ram_dout_o};
    n_tests++;
    if (obs !== 93'd0) begin n_fail++; $display("FAIL midreset_outputs: got %h expected 0", obs); end
    @(negedge clk);
    rst = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (bus.mem_done_o || bus.if_done_o || bus.ram_we_o || bus.ram_addr_o != 17'h0) spurious = 1'b1;
    end
    n_tests++;
    if (spurious) begin n_fail++; $display("FAIL midreset_idle: got activity expected none"); end
    shadow[17'h40] = 8'hDE;
    n_tests++;
    if ({ram[17'h40], ram[17'h41], ram[17'h42], ram[17'h43]} !== 32'hDE11_1111) begin
      n_fail++; $display("FAIL midreset_ram: got %h%h%h%h expected de111111", ram[17'h40], ram[17'h41], ram[17'h42], ram[17'h43]);
    end
  endtask

  task automatic test_empty_select();
    int lat; logic [31:0] rd;
    run_access(1'b1, 1'b1, 32'h0000_0088, 4'b0000, 32'hFFFF_FFFF, lat, rd);
    n_tests++;
    if (lat !== 1 || rd !== 32'h0) begin n_fail++; $display("FAIL empty_sel: got T%0d data %h expected T1 0", lat, rd); end
    n_tests++;
    if (tr_we[1] !== 1'b0 || tr_addr[1] !== 17'h0) begin
      n_fail++; $display("FAIL empty_sel_bus: got we %b addr %h expected 0 0", tr_we[1], tr_addr[1]);
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd; logic [31:0] a; logic [31:0] d; logic [31:0] exp_d;
    logic [3:0] sel; bit use_mem; bit we; bit bad; int n; int k; int mism = 0;
    for (int i = 0; i < 8; i++) preload(17'($urandom_range(0, 1023)), 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      use_mem = 1'($urandom);
      a = 32'($urandom_range(0, 1023)) | (32'($urandom) & 32'hFFFE_0000);
      d = $urandom;
      we  = use_mem ? 1'($urandom) : 1'b0;
      sel = use_mem ? 4'($urandom) : 4'b1111;
      exp_d = exp_load(a, sel);
      n = $countones(sel);
      run_access(use_mem, we, a, sel, d, lat, rd);
      if (we) model_store(a, sel, d);
      n_tests++;
      if (lat !== exp_lat(we, sel)) begin
        n_fail++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, exp_lat(we, sel));
      end
      if (!we) begin
        n_tests++;
        if (rd !== exp_d) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h expected %h", i, rd, exp_d); end
      end
      bad = 1'b0;
      for (int t = 1; t < lat && t < 16; t++) begin
        k = exp_lane(sel, t);
        if (k < 0) begin
          if (tr_addr[t] !== 17'h0 || tr_we[t] !== 1'b0) bad = 1'b1;
        end else begin
          if (tr_addr[t] !== {a[16:2], 2'(k)} || tr_we[t] !== we) bad = 1'b1;
          if (we && tr_dout[t] !== d[31-8*k -: 8]) bad = 1'b1;
        end
      end
      n_tests++;
      if (bad || after_done !== 1'b0 || tr_stall[0] !== 1'b1) begin
        n_fail++; $display("FAIL rnd_trace[%0d]: got mismatching bus trace expected %0d lanes sel %b", i, n, sel);
      end
    end
    for (int i = 0; i < 1024; i++) if (ram[i] !== shadow[i]) mism++;
    n_tests++;
    if (mism != 0) begin n_fail++; $display("FAIL rnd_ram_contents: got %0d differing bytes expected 0", mism); end
  endtask

  initial begin
    bus.if_req_i = 1'b0; bus.if_addr_i = 32'h0; bus.mem_ce_i = 1'b0; bus.mem_we_i = 1'b0;
    bus.mem_addr_i = 32'h0; bus.mem_sel_i = 4'b0000; bus.mem_data_i = 32'h0;
    test_reset();
    test_word_fetch();
    test_byte_load();
    test_word_store();
    test_simultaneous();
    test_reset_mid_store();
    test_empty_select();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single shared byte-wide RAM port serving two requesters: instruction fetch (IF) and the MEM stage.
- Each 32-bit request is serialized into one byte access per selected lane. Results are returned with a one-cycle done pulse.
- A combined stall request holds the pipeline while any request is outstanding.
- Sits between the IF/MEM stages and the RAM. Lane convention is big-endian: byte offset 0 maps to data[31:24] and sel[3].

Parameters:
RAM_ADDR_W, 17, width of the RAM byte address (ram_addr_o).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
if_req_i  in  1  IF word-fetch request; held until if_done_o
if_addr_i  in  32  IF byte address; bits [1:0] ignored
if_data_o  out  32  fetched word
if_done_o  out  1  one-cycle pulse, if_data_o valid
mem_ce_i  in  1  MEM-stage request; held until mem_done_o
mem_we_i  in  1  1 = store, 0 = load
mem_addr_i  in  32  MEM byte address; bits [1:0] ignored for lane selection
mem_sel_i  in  4  lane enables; sel[3] = offset 0
mem_data_i  in  32  store data, lane-aligned
mem_data_o  out  32  load data, lane-aligned; unselected lanes are 0
mem_done_o  out  1  one-cycle pulse, MEM access complete
stallreq_o  out  1  pipeline stall request
ram_addr_o  out  RAM_ADDR_W  RAM byte address
ram_we_o  out  1  RAM write enable
ram_dout_o  out  8  RAM write data
ram_din_i  in  8  RAM read data, valid one cycle after address

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; lane pointer and all latches cleared.
  - All outputs 0, including if_data_o and mem_data_o.
  - Bytes already written before reset remain written.
- RAM model:
  - Address is sampled at the rising edge; read data appears on ram_din_i in the following cycle.
  - A write occurs at the edge where ram_we_o=1.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE (cycle T0):
  - If mem_ce_i=1: grant MEM.
  - Else if if_req_i=1: grant IF with sel=1111, we=0.
  - At grant, latch address, sel, we and write data.
  - If latched sel=0000: go directly to DONE.
  - Otherwise go to ISSUE with the lane pointer at the lowest-offset selected lane.
  - While IDLE, ram_addr_o=0 and ram_we_o=0.
- ISSUE (cycles T1..Tn, where n = number of selected lanes):
  - Each cycle drives ram_addr_o={addr[RAM_ADDR_W-1:2], k} for the current selected offset k.
  - Lanes are visited in ascending offset order; unselected lanes are skipped with no idle cycle.
  - Store: ram_we_o=1, ram_dout_o=data[31-8k -: 8].
  - Load: ram_we_o=0; the byte for the lane issued in the previous cycle is captured into result[31-8k' -: 8].
  - After the last lane: a load goes to WAIT, a store goes to DONE.
- WAIT (cycle Tn+1, loads only):
  - Capture the final byte; ram_we_o=0; go to DONE.
- DONE:
  - Assert the granted port's done flag for this cycle only; its data output is valid.
  - Requests are ignored; go to IDLE.
  - if_data_o / mem_data_o hold their value until that port's next grant clears and refills them.
- Latency from T0 to the done cycle:
  - Load: n+2 cycles (IF word fetch = 6, byte load = 3).
  - Store: n+1 cycles (word store = 5).
  - sel=0000: 1 cycle.
- Arbitration:
  - MEM has fixed priority over IF.
  - When both are requested simultaneously, MEM is served first. IF is granted at the IDLE following that MEM access's DONE, unless a new mem_ce_i is present.
- stallreq_o = (mem_ce_i & ~mem_done_o) | (if_req_i & ~if_done_o), combinational.
- Request inputs changing after grant have no effect on the access in progress.
- Non-naturally-aligned selects (e.g. sel=0010 at addr[1:0]=00) are not checked; lanes follow sel only.

Test Plan:
- Word fetch: RAM[0x100..0x103]=11,22,33,44; if_req_i=1, if_addr_i=0x100 at T0 -> ram_addr_o=0x100,0x101,0x102,0x103 in T1..T4; if_done_o=1 in T6 only; if_data_o=0x11223344.
- Byte load: RAM[0x203]=0xAB; mem_ce_i=1, we=0, addr=0x203, sel=0001 -> single access at 0x203 in T1; mem_done_o in T3; mem_data_o=0x000000AB; stallreq_o=1 in T0..T2 and 0 in T3.
- Word store: data 0xDEADBEEF, addr 0x40, sel=1111 -> ram_we_o=1 in T1..T4 writing DE,AD,BE,EF to 0x40..0x43; mem_done_o in T5.
- Simultaneous requests: IF (0x0) and MEM halfword load (0x12, sel=0011) both at T0 -> MEM issues 0x12,0x13 in T1..T2, mem_done_o in T4; IF granted T5, if_done_o in T11.
- Reset mid-store: rst=0 during T2 of the word store above -> all outputs 0 immediately; RAM[0x40]=DE, RAM[0x41..0x43] unchanged; after release, IDLE with no spurious done.
- Empty select: mem_ce_i=1, sel=0000 -> no ram_we_o and ram_addr_o stays 0; mem_done_o in T1; mem_data_o=0.
